br_ctrl_fsm: RTL and testbench

- Control sequencer for the SLC-3 datapath.
- Runs the fetch/decode loop and drives the datapath load and gate enables, including ld_cc, which loads the condition-code flags.
- Consumes the combinational branch-enable result (branch) that the condition-code logic produces from IR[11:9] and the stored n/z/p flags.
- Executes ADD, AND, NOT, BR and PSE (pause). Every other opcode is retired as a NOP.

---
 rtl/br_ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_br_ctrl_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/br_ctrl_fsm.sv
// SLC-3 control sequencer: fetch/decode loop plus ADD, AND, NOT, BR and PSE execution.
// Outputs are decoded from the current state; sr2mux additionally follows ir[5] in the ALU states.
module br_ctrl_fsm #(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        continue_i,
    input  logic [15:0] ir,
    input  logic        branch,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_reg,
    output logic        ld_cc,
    output logic        gate_pc,
    output logic        gate_mdr,
    output logic        gate_alu,
    output logic        gate_marmux,
    output logic [1:0]  pcmux,
    output logic        addr1mux,
    output logic [1:0]  addr2mux,
    output logic [1:0]  aluk,
    output logic        sr2mux,
    output logic        mem_ena,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        HALTED      = 4'd0,
        S_FETCH1    = 4'd1,
        S_FETCH2    = 4'd2,
        S_FETCH3    = 4'd3,
        S_DECODE    = 4'd4,
        S_ADD       = 4'd5,
        S_AND       = 4'd6,
        S_NOT       = 4'd7,
        S_BR        = 4'd8,
        S_BR_TAKE   = 4'd9,
        S_PAUSE     = 4'd10,
        S_PAUSE_REL = 4'd11
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t     state_reg, state_next;
    logic       ben_reg, ben_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic       mem_done;

    // Only the opcode and the imm5 select bit steer the sequencer.
    logic unused_ir;
    assign unused_ir = &{1'b0, ir[11:6], ir[4:0]};

    assign mem_done = (wait_cnt_reg == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= HALTED;
            ben_reg      <= 1'b0;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            ben_reg      <= ben_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ben_next      = ben_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            HALTED:   if (run) state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: begin
                if (mem_done) begin
                    wait_cnt_next = 4'd0;
                    state_next    = S_FETCH3;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            S_FETCH3: state_next = S_DECODE;
            S_DECODE: begin
                // BEN captures the flags as they stand during decode, not later in S_BR.
                ben_next = branch;
                case (ir[15:12])
                    4'b0001: state_next = S_ADD;
                    4'b0101: state_next = S_AND;
                    4'b1001: state_next = S_NOT;
                    4'b0000: state_next = S_BR;
                    4'b1101: state_next = S_PAUSE;
                    default: state_next = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: state_next = S_FETCH1;
            S_BR:        state_next = ben_reg ? S_BR_TAKE : S_FETCH1;
            S_BR_TAKE:   state_next = S_FETCH1;
            S_PAUSE:     if (continue_i) state_next = S_PAUSE_REL;
            S_PAUSE_REL: if (!continue_i) state_next = S_FETCH1;
            default: begin
                state_next    = HALTED;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    always_comb begin
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        ld_ir       = 1'b0;
        ld_pc       = 1'b0;
        ld_reg      = 1'b0;
        ld_cc       = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        pcmux       = 2'b00;
        addr1mux    = 1'b0;
        addr2mux    = 2'b00;
        aluk        = 2'b00;
        sr2mux      = 1'b0;
        mem_ena     = 1'b0;
        case (state_reg)
            S_FETCH1: begin
                gate_pc = 1'b1;
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
            end
            S_FETCH2: begin
                mem_ena = 1'b1;
                ld_mdr  = mem_done;
            end
            S_FETCH3: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
            end
            S_ADD, S_AND, S_NOT: begin
                gate_alu = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
                aluk     = (state_reg == S_ADD) ? 2'b00 :
                           (state_reg == S_AND) ? 2'b01 : 2'b10;
                sr2mux   = (state_reg != S_NOT) && ir[5];
            end
            S_BR_TAKE: begin
                ld_pc    = 1'b1;
                pcmux    = 2'b01;
                addr2mux = 2'b10;
            end
            default: ;
        endcase
    end

    assign state_o = state_reg;

endmodule

// File: tb/tb_br_ctrl_fsm.sv
// Randomized bench for br_ctrl_fsm: a per-instruction trace generator predicts the
// control outputs of every cycle from the opcode, the BEN sample and the continue schedule.
module tb_br_ctrl_fsm;

    localparam int MW = 2;

    logic        clk = 1'b0;
    logic        reset, run, continue_i, branch;
    logic [15:0] ir;
    logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
    logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0]  pcmux, addr2mux, aluk;
    logic        addr1mux, sr2mux, mem_ena;
    logic [3:0]  state_o;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       sr2mux, mem_ena;
    } outs_t;

    outs_t obs;
    assign obs = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, gate_pc, gate_mdr,
                  gate_alu, gate_marmux, pcmux, addr1mux, addr2mux, aluk, sr2mux, mem_ena};

    br_ctrl_fsm #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .run(run), .continue_i(continue_i), .ir(ir),
        .branch(branch), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir),
        .ld_pc(ld_pc), .ld_reg(ld_reg), .ld_cc(ld_cc), .gate_pc(gate_pc),
        .gate_mdr(gate_mdr), .gate_alu(gate_alu), .gate_marmux(gate_marmux),
        .pcmux(pcmux), .addr1mux(addr1mux), .addr2mux(addr2mux), .aluk(aluk),
        .sr2mux(sr2mux), .mem_ena(mem_ena), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    outs_t exp_q[$];
    bit    br_q[$];
    bit    co_q[$];

    function automatic outs_t zero_outs();
        outs_t o;
        o = '0;
        return o;
    endfunction

    task automatic push(input outs_t o, input bit b, input bit c);
        exp_q.push_back(o);
        br_q.push_back(b);
        co_q.push_back(c);
    endtask

    // Builds the expected cycle-by-cycle trace of one instruction, starting at its first fetch cycle.
    task automatic build(input logic [15:0] iv, input bit bdec, input bit flip_br,
                         input int w, input int h);
        outs_t o;
        int    decode_idx;
        exp_q.delete(); br_q.delete(); co_q.delete();
        o = zero_outs(); o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1;
        push(o, 1'($urandom), 0);
        for (int i = 0; i < MW; i++) begin
            o = zero_outs(); o.mem_ena = 1; o.ld_mdr = (i == MW - 1);
            push(o, 1'($urandom), 0);
        end
        o = zero_outs(); o.gate_mdr = 1; o.ld_ir = 1;
        push(o, 1'($urandom), 0);
        decode_idx = exp_q.size();
        push(zero_outs(), bdec, 0);
        case (iv[15:12])
            4'h1, 4'h5, 4'h9: begin
                o = zero_outs(); o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1;
                o.aluk   = (iv[15:12] == 4'h1) ? 2'd0 : (iv[15:12] == 4'h5) ? 2'd1 : 2'd2;
                o.sr2mux = (iv[15:12] != 4'h9) && iv[5];
                push(o, 1'($urandom), 0);
            end
            4'h0: begin
                push(zero_outs(), flip_br ? !bdec : 1'($urandom), 0);
                if (bdec) begin
                    o = zero_outs(); o.ld_pc = 1; o.pcmux = 2'b01; o.addr2mux = 2'b10;
                    push(o, 1'($urandom), 0);
                end
            end
            4'hD: begin
                if (w == 0) co_q[decode_idx] = 1;
                for (int j = 0; j <= w + h; j++)
                    push(zero_outs(), 1'($urandom), (j >= w) && (j < w + h));
            end
            default: ;
        endcase
    endtask

    // Entered at a negedge with the DUT in its first fetch cycle; leaves at the next fetch.
    task automatic run_instr(input logic [15:0] iv, input bit bdec, input bit flip_br,
                             input int w, input int h);
        build(iv, bdec, flip_br, w, h);
        ir = iv;
        for (int i = 0; i < exp_q.size(); i++) begin
            branch     = br_q[i];
            continue_i = co_q[i];
            run        = 1'($urandom);
            #1;
            check($sformatf("ir%04h_cyc%0d_outs", iv, i), 32'(obs), 32'(exp_q[i]));
            check($sformatf("ir%04h_cyc%0d_running", iv, i), 32'(state_o != 4'd0), 32'd1);
            @(negedge clk);
        end
        $display("[TB] ir=%04h ben=%0d cycles=%0d", iv, bdec, exp_q.size());
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        int          k;
        v = 16'($urandom);
        k = $urandom_range(0, 7);
        case (k)
            0: v[15:12] = 4'h1;
            1: v[15:12] = 4'h5;
            2: v[15:12] = 4'h9;
            3: v[15:12] = 4'h0;
            4: v[15:12] = 4'hD;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic [15:0] iv;
        reset = 1; run = 0; continue_i = 0; branch = 0; ir = 16'h0;
        #2;
        check("async_reset_state", 32'(state_o), 32'd0);
        check("async_reset_outs", 32'(obs), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            branch = 1'($urandom); continue_i = 1'($urandom); ir = 16'($urandom);
            @(negedge clk);
            check("halted_state", 32'(state_o), 32'd0);
            check("halted_outs", 32'(obs), 32'd0);
        end
        continue_i = 0;
        run = 1;
        @(negedge clk);

        run_instr(16'h1021, 1'b0, 1'b0, 0, 1);
        run_instr(16'h0402, 1'b1, 1'b0, 0, 1);
        run_instr(16'h0402, 1'b0, 1'b0, 0, 1);
        run_instr(16'h0402, 1'b1, 1'b1, 0, 1);
        run_instr(16'hD000, 1'b0, 1'b0, 0, 3);
        run_instr(16'hD000, 1'b0, 1'b0, 2, 1);
        run_instr(16'h5020, 1'b1, 1'b0, 0, 1);
        run_instr(16'h903F, 1'b0, 1'b0, 0, 1);
        run_instr(16'h3000, 1'b1, 1'b0, 0, 1);

        // Reset during the second wait cycle, then a clean restart.
        ir = 16'h1021;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1;
        check("midwait_reset_state", 32'(state_o), 32'd0);
        check("midwait_reset_outs", 32'(obs), 32'd0);
        @(negedge clk);
        check("reset_held_state", 32'(state_o), 32'd0);
        reset = 0;
        run = 1;
        @(negedge clk);
        run_instr(16'h1021, 1'b0, 1'b0, 0, 1);

        for (int n = 0; n < 60; n++) begin
            iv = rand_instr();
            run_instr(iv, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
